// File: rtl/rr_request_arbiter_if.sv
// Request/grant bundle between requester agents and the round-robin arbiter.
// The master side drives requests and release; the slave side (arbiter) returns the grant.
interface rr_request_arbiter_if #(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = 2
);
   logic [N-1:0]   req;
   logic           done;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_valid;
   logic           timeout;

   modport master (
      output req, done,
      input  gnt, gnt_id, gnt_valid, timeout
   );

   modport slave (
      input  req, done,
      output gnt, gnt_id, gnt_valid, timeout
   );
endinterface

// File: rtl/rr_request_arbiter.sv
// Round-robin arbiter: rotating-priority pick, grant held until done, withdrawal or hold limit.
// All outputs registered; a one-cycle idle bubble always separates consecutive grants.
module rr_request_arbiter #(
   parameter int unsigned N        = 4,
   parameter int unsigned IDW      = 2,
   parameter int unsigned MAX_HOLD = 8
) (
   input logic                  clk,
   input logic                  rst,
   rr_request_arbiter_if.slave  bus
);

   localparam int unsigned CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state_q;
   logic [IDW-1:0] ptr_q;
   logic [CW-1:0]  cnt_q;
   logic [N-1:0]   gnt_q;
   logic [IDW-1:0] gnt_id_q;
   logic           gnt_valid_q;
   logic           timeout_q;

   logic [IDW-1:0] win_id_d;
   logic [N-1:0]   win_oh_d;
   logic           win_any_d;
   logic [IDW-1:0] ptr_d;
   logic           rel_user_d;
   logic           rel_hold_d;
   int unsigned    idx;

   // Circular scan starting at ptr; the first set request wins.
   always_comb begin
      win_id_d  = '0;
      win_oh_d  = '0;
      win_any_d = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = k + {{(32-IDW){1'b0}}, ptr_q};
         if (idx >= N) idx = idx - N;
         if (!win_any_d && bus.req[idx]) begin
            win_any_d     = 1'b1;
            win_id_d      = IDW'(idx);
            win_oh_d[idx] = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d      = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
      rel_user_d = bus.done || !bus.req[gnt_id_q];
      rel_hold_d = (MAX_HOLD != 0) && (cnt_q == CW'(HOLD_LAST));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_any_d) begin
                  gnt_q       <= win_oh_d;
                  gnt_id_q    <= win_id_d;
                  gnt_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= BUSY;
               end
            end
            BUSY: begin
               if (rel_user_d || rel_hold_d) begin
                  gnt_q       <= '0;
                  gnt_valid_q <= 1'b0;
                  ptr_q       <= ptr_d;
                  timeout_q   <= rel_hold_d && !rel_user_d;
                  state_q     <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Directed bench for rr_request_arbiter with hand-computed expectations.
module tb_rr_request_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   rr_request_arbiter_if #(.N(4), .IDW(2)) arb_if ();

   rr_request_arbiter #(.N(4), .IDW(2), .MAX_HOLD(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (arb_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst         = 1'b1;
      arb_if.req  = '0;
      arb_if.done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic expect_grant(input string tag, input int id);
      check({tag, "_valid"}, arb_if.gnt_valid, 1);
      check({tag, "_id"}, arb_if.gnt_id, id);
      check({tag, "_gnt"}, arb_if.gnt, 32'd1 << id);
      check({tag, "_tmo"}, arb_if.timeout, 0);
   endtask

   task automatic expect_idle(input string tag, input int tmo);
      check({tag, "_valid"}, arb_if.gnt_valid, 0);
      check({tag, "_gnt"}, arb_if.gnt, 0);
      check({tag, "_tmo"}, arb_if.timeout, tmo);
   endtask

   initial begin
      int seq[5];
      checks = 0;
      errors = 0;
      seq = '{0, 1, 2, 3, 0};

      // Reset state
      do_reset();
      expect_idle("rst", 0);
      check("rst_id", arb_if.gnt_id, 0);

      // 1: single request, release by done, ptr moves to 2
      arb_if.req = 4'b0010;
      tick();
      expect_grant("single", 1);
      arb_if.done = 1'b1;
      tick();
      expect_idle("single_rel", 0);
      check("single_rel_id", arb_if.gnt_id, 1);
      arb_if.done = 1'b0;
      arb_if.req  = 4'b0011;
      tick();
      expect_grant("ptr2_wrap", 0);
      arb_if.done = 1'b1;
      tick();
      arb_if.done = 1'b0;
      arb_if.req  = '0;

      // 2: full contention rotates 0,1,2,3,0 with an idle bubble
      do_reset();
      arb_if.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_grant("rot", seq[i]);
         tick();
         check("rot_hold", arb_if.gnt_valid, 1);
         arb_if.done = 1'b1;
         tick();
         expect_idle("rot_gap", 0);
         arb_if.done = 1'b0;
      end

      // 3: ptr=1, sparse requests skip and wrap
      arb_if.req = 4'b0101;
      tick();
      expect_grant("skip", 2);
      arb_if.done = 1'b1;
      tick();
      expect_idle("skip_rel", 0);
      arb_if.done = 1'b0;
      tick();
      expect_grant("skip_wrap", 0);
      arb_if.done = 1'b1;
      tick();
      arb_if.done = 1'b0;
      arb_if.req  = '0;

      // 4: hold limit forces release after exactly 8 cycles
      do_reset();
      arb_if.req = 4'b1001;
      for (int i = 0; i < 8; i++) begin
         tick();
         expect_grant("hold", 0);
      end
      tick();
      expect_idle("hold_tmo", 1);
      tick();
      expect_grant("hold_next", 3);

      // done released holder 3; then holder 2 withdraws mid-grant
      arb_if.done = 1'b1;
      tick();
      expect_idle("done3", 0);
      arb_if.done = 1'b0;
      arb_if.req  = 4'b0100;
      tick();
      expect_grant("wd", 2);
      tick();
      expect_grant("wd_hold", 2);
      arb_if.req = 4'b0000;
      tick();
      expect_idle("wd_rel", 0);
      arb_if.req = 4'b1000;
      tick();
      expect_grant("pre_rst", 3);

      // 5: asynchronous reset mid-grant
      #2;
      rst = 1'b1;
      #1;
      expect_idle("async_rst", 0);
      check("async_rst_id", arb_if.gnt_id, 0);
      arb_if.req = 4'b1111;
      tick();
      expect_idle("rst_held", 0);
      rst = 1'b0;
      tick();
      expect_grant("post_rst", 0);

      // Hold limit coinciding with done gives no timeout pulse
      do_reset();
      arb_if.req = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         tick();
         expect_grant("coinc", 0);
      end
      arb_if.done = 1'b1;
      tick();
      expect_idle("coinc_rel", 0);

      // 6: idle with done toggling stays quiet
      arb_if.req = '0;
      for (int i = 0; i < 20; i++) begin
         arb_if.done = ~arb_if.done;
         tick();
         check("quiet_valid", arb_if.gnt_valid, 0);
         check("quiet_tmo", arb_if.timeout, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_request_arbiter.md
Name: rr_request_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource (bus or datapath slot) among N requesters.
- Resolves simultaneous requests with a rotating-priority encoder.
- Holds each grant until the holder releases it or a hold limit expires.
- Sits between the requester agents and the shared resource; its grant_id drives the resource's input mux select.

Parameters:
- N, 4, number of requesters (N >= 2).
- IDW, 2, width of grant index; must equal ceil(log2(N)).
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held; 0 disables the limit.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i is high while requester i wants the resource.
- done  input  1  current holder finished; releases the grant.
- gnt  output  N  one-hot grant vector; all zeros when idle.
- gnt_id  output  IDW  binary index of the granted requester; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - Outputs: gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - Internal: state=IDLE, pointer ptr=0, hold counter cnt=0.
- Arbitration:
  - Winner is the first set bit of req, scanning circularly upward from index ptr (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
- State IDLE:
  - If req != 0 at a rising edge: gnt <= onehot(winner), gnt_id <= winner, gnt_valid <= 1, cnt <= 0, state <= BUSY.
  - Latency: a grant appears 1 cycle after req is sampled.
  - If req == 0: stay in IDLE with outputs at zero.
  - done is ignored in IDLE.
- State BUSY:
  - gnt, gnt_id and gnt_valid hold steady.
  - cnt increments every cycle.
  - Changes on other requesters' req bits are ignored.
  - Release conditions, evaluated at each edge:
    - (a) done=1;
    - (b) req[gnt_id]=0, i.e. the holder withdrew;
    - (c) MAX_HOLD != 0 and cnt == MAX_HOLD-1, so a grant lasts at most MAX_HOLD cycles.
  - On release: gnt <= 0, gnt_valid <= 0, gnt_id holds its value, ptr <= (gnt_id+1) mod N, state <= IDLE.
- Timeout pulse:
  - timeout <= 1 for one cycle only when release is caused by (c) alone.
  - If done or holder withdrawal coincides with (c), timeout stays 0.
- Inter-grant gap:
  - A mandatory 1-cycle IDLE bubble separates consecutive grants, so gnt_valid is low for at least 1 cycle between them.
  - Back-to-back grants never overlap; gnt is always one-hot or zero.
- Pointer wrap:
  - A winner of N-1 sets ptr to 0.
  - ptr is updated only on release, never on grant.
- Fairness:
  - With all requesters continuously asserting, grants rotate 0,1,...,N-1,0.
  - No requester waits more than N-1 grants.
- Simultaneous events:
  - A new request arriving in the same cycle as a release is considered in the following IDLE cycle, using the updated ptr.

Test Plan:
1. Single request: rst pulse, then req=0010 -> next edge gnt=0010, gnt_id=01, gnt_valid=1; drive done=1 for one cycle -> gnt=0000, gnt_valid=0, ptr=2.
2. Full contention: req=1111 held, done pulsed 2 cycles after each grant -> gnt_id sequence 0,1,2,3,0, with a 1-cycle gnt_valid=0 gap between grants.
3. Rotation skip: ptr=1 (after serving 0), req=0101 -> gnt_id=2; after release, req=0101 -> gnt_id=0 (wraps past 3).
4. Hold limit: MAX_HOLD=8, req=1001 held, done=0 -> gnt=0001 for exactly 8 cycles, then timeout=1 for one cycle and gnt=0000; the next grant is gnt=1000.
5. Withdrawal and reset: holder 2 drops req[2] mid-grant -> release on the next edge with timeout=0; then, while holder 3 is granted, assert rst mid-cycle -> gnt=0, gnt_valid=0 immediately, and after rst deasserts with req=1111 the first grant goes to index 0.
6. Idle quiet: req=0000 with done toggling -> gnt_valid stays 0 and timeout stays 0 for 20 cycles.
